// File: rtl/note_encoder_pkg.sv
// Shared display/note definitions: note codes, octave limits, payload type and encoder state encoding.
package note_encoder_pkg;

    localparam int unsigned NUM_KEYS = 12;
    localparam int unsigned NOTE_W   = 4;
    localparam int unsigned OCT_W    = 2;

    localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_A    = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_AS   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_B    = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_C    = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_CS   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_D    = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_DS   = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_E    = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_F    = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_FS   = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_G    = 4'd11;
    localparam logic [NOTE_W-1:0] NOTE_GS   = 4'd12;

    localparam logic [OCT_W-1:0] OCT_MIN = 2'd0;
    localparam logic [OCT_W-1:0] OCT_MAX = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } enc_state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [OCT_W-1:0]  octave;
    } glyph_t;

    // Lowest pressed key wins; no key pressed yields NOTE_NONE.
    function automatic logic [NOTE_W-1:0] lowest_note(input logic [NUM_KEYS-1:0] k);
        logic [NOTE_W-1:0] n;
        n = NOTE_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (k[i]) n = NOTE_W'(i + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/note_encoder_if.sv
// Note/octave publish channel between the encoder and the glyph-drawing stage.
interface note_encoder_if;
    import note_encoder_pkg::*;

    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  octave;
    logic              redraw_req;
    logic              redraw_ack;

    modport master (output note, output octave, output redraw_req, input redraw_ack);
    modport slave  (input note, input octave, input redraw_req, output redraw_ack);
endinterface

// File: rtl/note_encoder_debounce.sv
// Two-flop synchronizer plus saturating stability counter for one raw button input.
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Level flips on the cycle the counter reaches CNT_MAX; any agreeing cycle restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_MAX - CNT_W'(1)) level <= sync_q[1];
            end
        end
    end

endmodule

// File: rtl/note_encoder.sv
// Debounces keys/octave buttons, encodes the lowest pressed note and publishes note/octave with a redraw handshake.
module note_encoder
    import note_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                oct_up,
    input  logic                oct_down,
    note_encoder_if.master      disp
);

    localparam int unsigned NUM_IN = NUM_KEYS + 2;

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] level;

    assign raw = {oct_down, oct_up, keys};

    for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
        debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[g]),
            .level (level[g])
        );
    end

    logic up_level, dn_level, up_prev_q, dn_prev_q, up_rise, dn_rise;
    logic [OCT_W-1:0] cand_oct_q;

    assign up_level = level[NUM_KEYS];
    assign dn_level = level[NUM_KEYS+1];
    assign up_rise  = up_level & ~up_prev_q;
    assign dn_rise  = dn_level & ~dn_prev_q;

    // Candidate octave moves only on a lone debounced rising edge, saturating at the limits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_prev_q  <= 1'b0;
            dn_prev_q  <= 1'b0;
            cand_oct_q <= OCT_MIN;
        end else begin
            up_prev_q <= up_level;
            dn_prev_q <= dn_level;
            if (up_rise && !dn_rise && cand_oct_q != OCT_MAX) begin
                cand_oct_q <= cand_oct_q + OCT_W'(1);
            end else if (dn_rise && !up_rise && cand_oct_q != OCT_MIN) begin
                cand_oct_q <= cand_oct_q - OCT_W'(1);
            end
        end
    end

    glyph_t     cand_c;
    glyph_t     pub_q, pub_d;
    logic       req_q, req_d;
    enc_state_e state_q, state_d;

    assign cand_c.note   = lowest_note(level[NUM_KEYS-1:0]);
    assign cand_c.octave = cand_oct_q;

    // Publish handshake: values are frozen while a redraw is outstanding.
    always_comb begin
        state_d = state_q;
        pub_d   = pub_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_c != pub_q) begin
                    pub_d   = cand_c;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (disp.redraw_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pub_q   <= '{note: NOTE_NONE, octave: OCT_MIN};
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pub_q   <= pub_d;
            req_q   <= req_d;
        end
    end

    assign disp.note       = pub_q.note;
    assign disp.octave     = pub_q.octave;
    assign disp.redraw_req = req_q;

endmodule

// File: tb/tb_note_encoder.sv
// Directed bench for note_encoder with a short debounce window.
module tb_note_encoder;
    import note_encoder_pkg::*;

    localparam int unsigned DEB = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NUM_KEYS-1:0] keys = '0;
    logic                oct_up = 1'b0;
    logic                oct_down = 1'b0;

    note_encoder_if disp_if ();

    note_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk      (clk),
        .reset    (reset),
        .keys     (keys),
        .oct_up   (oct_up),
        .oct_down (oct_down),
        .disp     (disp_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        disp_if.redraw_ack = 1'b1;
        step(1);
        disp_if.redraw_ack = 1'b0;
    endtask

    initial begin
        logic seen_req;
        disp_if.redraw_ack = 1'b0;

        step(3);
        check_eq("rst_note", 32'(disp_if.note), 0);
        check_eq("rst_req", 32'(disp_if.redraw_req), 0);
        reset = 1'b1;

        // Idle after reset: nothing to publish.
        seen_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (disp_if.redraw_req) seen_req = 1'b1;
        end
        check_eq("idle_req", 32'(seen_req), 0);
        check_eq("idle_note", 32'(disp_if.note), 0);
        check_eq("idle_oct", 32'(disp_if.octave), 0);

        // C pressed: published exactly DEB+3 edges after first sampling edge.
        keys = 12'h008;
        step(DEB + 2);
        check_eq("c_early_note", 32'(disp_if.note), 0);
        check_eq("c_early_req", 32'(disp_if.redraw_req), 0);
        step(1);
        check_eq("c_note", 32'(disp_if.note), 4);
        check_eq("c_req", 32'(disp_if.redraw_req), 1);
        step(3);
        check_eq("c_req_held", 32'(disp_if.redraw_req), 1);
        ack_pulse();
        check_eq("c_req_clr", 32'(disp_if.redraw_req), 0);
        check_eq("c_note_kept", 32'(disp_if.note), 4);

        // Release to no keys blanks the note.
        keys = 12'h000;
        step(DEB + 3);
        check_eq("rel_note", 32'(disp_if.note), 0);
        check_eq("rel_req", 32'(disp_if.redraw_req), 1);
        ack_pulse();

        // A and G# together: A wins; drop A leaves G#.
        keys = 12'h801;
        step(DEB + 3);
        check_eq("ags_note", 32'(disp_if.note), 1);
        ack_pulse();
        keys = 12'h800;
        step(DEB + 3);
        check_eq("gs_note", 32'(disp_if.note), 12);
        check_eq("gs_req", 32'(disp_if.redraw_req), 1);
        ack_pulse();
        keys = 12'h000;
        step(DEB + 3);
        ack_pulse();

        // Octave up presses, saturating at 3.
        for (int p = 0; p < 4; p++) begin
            oct_up = 1'b1;
            step(10);
            oct_up = 1'b0;
            check_eq("oct_up", 32'(disp_if.octave), (p < 3) ? p + 1 : 3);
            check_eq("oct_up_req", 32'(disp_if.redraw_req), (p < 3) ? 1 : 0);
            if (disp_if.redraw_req) ack_pulse();
            step(8);
        end

        // Simultaneous up and down cancel.
        oct_up = 1'b1;
        oct_down = 1'b1;
        step(10);
        oct_up = 1'b0;
        oct_down = 1'b0;
        check_eq("oct_both", 32'(disp_if.octave), 3);
        check_eq("oct_both_req", 32'(disp_if.redraw_req), 0);
        step(8);
        oct_down = 1'b1;
        step(10);
        oct_down = 1'b0;
        check_eq("oct_down", 32'(disp_if.octave), 2);
        ack_pulse();
        step(8);

        // Changes during REQ are held off, then the latest value is republished.
        keys = 12'h020;
        step(DEB + 3);
        check_eq("d_note", 32'(disp_if.note), 6);
        check_eq("d_req", 32'(disp_if.redraw_req), 1);
        keys = 12'h100;
        step(8);
        check_eq("f_held_note", 32'(disp_if.note), 6);
        keys = 12'h080;
        step(8);
        check_eq("e_held_note", 32'(disp_if.note), 6);
        check_eq("e_held_req", 32'(disp_if.redraw_req), 1);
        ack_pulse();
        check_eq("e_ack_req", 32'(disp_if.redraw_req), 0);
        check_eq("e_ack_note", 32'(disp_if.note), 6);
        step(1);
        check_eq("e_note", 32'(disp_if.note), 8);
        check_eq("e_req", 32'(disp_if.redraw_req), 1);
        ack_pulse();

        // Glitch one cycle shorter than the debounce window is rejected.
        keys = 12'h081;
        step(DEB - 1);
        keys = 12'h080;
        step(10);
        check_eq("glitch_note", 32'(disp_if.note), 8);
        check_eq("glitch_req", 32'(disp_if.redraw_req), 0);

        // Reset mid-REQ clears outputs without a clock edge and abandons the request.
        keys = 12'h001;
        step(DEB + 3);
        check_eq("a_note", 32'(disp_if.note), 1);
        check_eq("a_req", 32'(disp_if.redraw_req), 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_note", 32'(disp_if.note), 0);
        check_eq("arst_oct", 32'(disp_if.octave), 0);
        check_eq("arst_req", 32'(disp_if.redraw_req), 0);
        keys = 12'h000;
        step(2);
        reset = 1'b1;
        seen_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (disp_if.redraw_req) seen_req = 1'b1;
        end
        check_eq("post_rst_req", 32'(seen_req), 0);
        check_eq("post_rst_note", 32'(disp_if.note), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/note_encoder.md
NOTE_ENCODER -- requirements
Module: note_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000 (5 ms at 50 MHz), which sets the consecutive stable cycles needed to accept an input level.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port keys, input, 12 bits: raw active-high semitone keys; index 0=A, 1=A#, 2=B, 3=C, 4=C#, 5=D, 6=D#, 7=E, 8=F, 9=F#, 10=G, 11=G#.
REQ-005 The block SHALL have the port oct_up, input, 1 bit: raw active-high octave-increment button.
REQ-006 The block SHALL have the port oct_down, input, 1 bit: raw active-high octave-decrement button.
REQ-007 The block SHALL have the port redraw_ack, input, 1 bit: a one-cycle pulse from the display stage when the glyph redraw is finished.
REQ-008 The block SHALL have the port note, output, 4 bits: published note code (0=none, 1..12 = key index+1), feeding the glyph-drawing stage.
REQ-009 The block SHALL have the port octave, output, 2 bits: published octave code (0..3 displays "1".."4").
REQ-010 The block SHALL have the port redraw_req, output, 1 bit: level request to the display stage to redraw the note/octave glyphs.

Function
REQ-011 Each of the 14 raw inputs SHALL pass through a 2-flop synchronizer followed by a debouncer.
- The debounced level flips only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- Any agreeing cycle clears that input's counter.
REQ-012 The candidate note SHALL be combinational from the debounced keys: 0 if no key is pressed, otherwise the lowest pressed index + 1; a lower index wins when several keys are pressed.
REQ-013 The candidate octave register SHALL update as follows:
- +1 on a debounced oct_up rising edge, saturating at 3.
- -1 on a debounced oct_down rising edge, saturating at 0.
- Unchanged when both edges occur in the same cycle.
- Unchanged by held levels.
REQ-014 The FSM SHALL have the states IDLE and REQ; the reset state is IDLE.
REQ-015 In IDLE, if {candidate note, candidate octave} differs from {note, octave}, the block SHALL on that edge load note/octave from the candidates, set redraw_req=1 and enter REQ; otherwise it remains in IDLE.
REQ-016 In REQ, note, octave and redraw_req=1 SHALL be held stable regardless of input changes; on redraw_ack=1 the block SHALL clear redraw_req and return to IDLE.
REQ-017 Changes arriving during REQ SHALL NOT be lost.
- Candidates keep tracking.
- The IDLE comparison on the cycle after the return republishes the latest values.
- Intermediate values may be skipped.
REQ-018 redraw_ack received in IDLE SHALL be ignored.
REQ-019 Key release to no keys SHALL be treated as a change: note is published as 0 and a redraw is requested to blank the letter.
REQ-020 Latency from the first clock edge sampling a new stable raw key level to the note update SHALL be DEBOUNCE_CYCLES+3 edges when the FSM is in IDLE.
REQ-021 A debounce counter SHALL saturate at DEBOUNCE_CYCLES and never wrap; counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)).

Reset
REQ-022 reset=0 SHALL immediately force:
- note=0, octave=0, redraw_req=0, FSM=IDLE, candidate octave=0;
- all synchronizer flops, debounced levels and counters to 0.
REQ-023 Reset asserted mid-REQ SHALL abandon the request; after release no redraw is issued until a candidate differs from the published values.

Structure
REQ-024 The note codes (NOTE_NONE=0, NOTE_A=1..NOTE_GS=12), OCT_MIN=0, OCT_MAX=3 and the state encoding SHALL live in the shared display/note package, which is also used by the glyph-drawing stage.
REQ-025 The per-input logic SHALL be the sub-module debounce (synchronizer + counter, parameter DEBOUNCE_CYCLES), instantiated 14 times; encoding, octave counter and FSM stay in note_encoder.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset release, inputs idle, 20 cycles -> note=0, octave=0, redraw_req stays 0.
REQ-027 keys=12'h008 (C) held -> 7 edges later note=4, redraw_req=1; held until redraw_ack pulse, then 0 on the next edge.
REQ-028 keys=12'h801 (A and G#) -> note=1; then release bit 0 -> note=12 after ack and debounce.
REQ-029 Three debounced oct_up presses, then a fourth -> octave 1, 2, 3, 3 (saturated); oct_down and oct_up pressed in the same cycle -> octave unchanged.
REQ-030 Press D (note=6, req=1), withhold ack, press F then E -> note stays 6 during REQ; ack -> next edge IDLE, following edge note=8 (E), req=1.
REQ-031 Glitch: key 0 high for 3 cycles then low -> no change; reset pulsed low mid-REQ -> outputs 0 asynchronously, no req after release.
